// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// FCT3 opcode encodings and FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage (master) and muldiv_unit (slave).
interface muldiv_if #(parameter int unsigned XLEN = 32) ();
  logic            req;
  logic            kill;
  logic [2:0]      fct3;
  logic [XLEN-1:0] u1reg;
  logic [XLEN-1:0] u2reg;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] rdata;

  modport master (output req, kill, fct3, u1reg, u2reg, input busy, done, rdata);
  modport slave  (input req, kill, fct3, u1reg, u2reg, output busy, done, rdata);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, sharing one XLEN+1 adder and one 2*XLEN shift register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FASTPATH = 1'b1
) (
  input  logic     clk,
  input  logic     resn,
  muldiv_if.slave  md
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = XLEN + 2;
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state, state_nxt;
  logic            busy_d, done_d;
  logic [2:0]      op_q;
  logic            neg_q, rneg_q, dz_q;
  logic [XLEN-1:0] acc, mq, opd;
  logic [CW-1:0]   cnt;

  // Operand decode, evaluated only at accept
  logic            s1, s2, a_neg, b_neg, is_div, dz, ov, fast, accept;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div = md.fct3[2];
  assign s1     = (md.fct3 == MD_MULH) || (md.fct3 == MD_MULHSU) ||
                  (md.fct3 == MD_DIV)  || (md.fct3 == MD_REM);
  assign s2     = (md.fct3 == MD_MULH) || (md.fct3 == MD_DIV) || (md.fct3 == MD_REM);
  assign a_neg  = s1 && md.u1reg[XLEN-1];
  assign b_neg  = s2 && md.u2reg[XLEN-1];
  assign a_mag  = a_neg ? (~md.u1reg + XLEN'(1)) : md.u1reg;
  assign b_mag  = b_neg ? (~md.u2reg + XLEN'(1)) : md.u2reg;
  assign dz     = is_div && (md.u2reg == '0);
  assign ov     = is_div && s2 && (md.u1reg == MIN_NEG) && (md.u2reg == '1);
  assign fast   = FASTPATH && (dz || ov);
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && md.req && !md.kill;

  // State register and registered status outputs
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state   <= ST_IDLE;
      md.busy <= 1'b0;
      md.done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md.busy <= busy_d;
      md.done <= done_d;
    end
  end

  // Next-state logic; kill overrides everything including a same-cycle request
  always_comb begin
    state_nxt = state;
    if (md.kill) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: state_nxt = md.req ? (fast ? ST_FIX : ST_RUN) : ST_IDLE;
        ST_RUN:           if (cnt == CW'(XLEN - 1)) state_nxt = ST_FIX;
        ST_FIX:           state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_nxt)
      ST_RUN, ST_FIX: busy_d = 1'b1;
      ST_DONE:        done_d = 1'b1;
      default:        ;
    endcase
  end

  // Shared adder: add for multiply, trial-subtract (carry = no borrow) for divide
  logic [XLEN:0] add_a, add_b, add_s;
  logic          add_ci, add_co;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (op_q[2]) begin
      add_a  = {acc, mq[XLEN-1]};
      add_b  = ~{1'b0, opd};
      add_ci = 1'b1;
    end else begin
      add_a  = {1'b0, acc};
      add_b  = mq[0] ? {1'b0, opd} : '0;
    end
    {add_co, add_s} = AW'(add_a) + AW'(add_b) + AW'(add_ci);
  end

  // Sign correction and result selection for the FIX cycle
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quot, rem, result_c;

  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_q ? (~prod + PW'(1)) : prod;
    quot     = dz_q ? '1 : (neg_q ? (~mq + XLEN'(1)) : mq);
    rem      = rneg_q ? (~acc + XLEN'(1)) : acc;
    unique case (op_q)
      MD_MUL:                       result_c = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_c = prod_fix[PW-1:XLEN];
      MD_DIV, MD_DIVU:              result_c = quot;
      default:                      result_c = rem;
    endcase
  end

  // Datapath registers; fastpath preloads acc/mq so FIX yields the special values
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      acc      <= '0;
      mq       <= '0;
      opd      <= '0;
      cnt      <= '0;
      md.rdata <= '0;
    end else if (accept) begin
      op_q   <= md.fct3;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= dz;
      opd    <= b_mag;
      mq     <= a_mag;
      acc    <= (fast && dz) ? a_mag : '0;
      cnt    <= '0;
    end else if (!md.kill) begin
      if (state == ST_RUN) begin
        cnt <= cnt + CW'(1);
        if (op_q[2]) begin
          acc <= add_co ? add_s[XLEN-1:0] : add_a[XLEN-1:0];
          mq  <= {mq[XLEN-2:0], add_co};
        end else begin
          acc <= add_s[XLEN:1];
          mq  <= {add_s[0], mq[XLEN-1:1]};
        end
      end
      if (state == ST_FIX) md.rdata <= result_c;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized
// operations checked against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk  = 1'b0;
  logic resn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) mif ();

  muldiv_unit #(.XLEN(32), .FASTPATH(1'b1)) dut (
    .clk  (clk),
    .resn (resn),
    .md   (mif.slave)
  );

  // RV32M semantics written directly from the ISA rules
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, p;
    int sa, sb;
    ae = (f == MD_MULH || f == MD_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    be = (f == MD_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ae * be;
    sa = a;
    sb = b;
    case (f)
      MD_MUL:                       return p[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: return p[63:32];
      MD_DIV:  if (b == 0) return 32'hFFFFFFFF; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a; else return 32'(sa / sb);
      MD_DIVU: if (b == 0) return 32'hFFFFFFFF; else return a / b;
      MD_REM:  if (b == 0) return a; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || ((f == MD_DIV || f == MD_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 2;
    return 34;
  endfunction

  // Issue one request (accept edge = cycle 0) and wait for DONE; cyc = -1 on timeout
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    mif.fct3 = f; mif.u1reg = a; mif.u2reg = b; mif.req = 1'b1;
    @(posedge clk); #1;
    mif.req = 1'b0; mif.u1reg = $urandom; mif.u2reg = $urandom; mif.fct3 = 3'($urandom);
    cyc = 1;
    while (!mif.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = mif.rdata;
    if (!mif.done) cyc = -1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b rdata=%h required 0/0/0", mif.busy, mif.done, mif.rdata);
    end
    @(negedge clk); resn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0/0", mif.busy, mif.done);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f [12] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM, MD_DIVU, MD_REMU,
                            MD_DIV, MD_REM, MD_DIV, MD_REM};
    logic [31:0] a [12] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] x [12] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                            32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int          l [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    logic [31:0] res;
    int          cyc;
    for (int i = 0; i < 12; i++) begin
      run_op(f[i], a[i], b[i], res, cyc);
      checks++;
      if (res !== x[i] || cyc != l[i]) begin
        errors++;
        $display("FAIL directed_%0d f=%0d: rdata=%h cycle=%0d required %h cycle %0d", i, f[i], res, cyc, x[i], l[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] edges [4] = '{32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd1};
    logic [2:0]  f;
    logic [31:0] a, b, res;
    int          cyc;
    for (int i = 0; i < 48; i++) begin
      f = 3'(i % 8);
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 32'($urandom);
      if (i % 5 == 0) b = b >> $urandom_range(0, 31);
      run_op(f, a, b, res, cyc);
      checks++;
      if (res !== ref_md(f, a, b) || cyc != ref_lat(f, a, b)) begin
        errors++;
        $display("FAIL random_%0d f=%0d a=%h b=%h: rdata=%h cycle=%0d required %h cycle %0d",
                 i, f, a, b, res, cyc, ref_md(f, a, b), ref_lat(f, a, b));
      end
    end
  endtask

  task automatic test_req_ignored();
    int cyc;
    mif.fct3 = MD_DIVU; mif.u1reg = 32'd100; mif.u2reg = 32'd7; mif.req = 1'b1;
    @(posedge clk); #1;
    mif.req = 1'b0;
    cyc = 1;
    while (!mif.done && cyc < 100) begin
      if (cyc == 5) begin
        mif.req = 1'b1; mif.fct3 = MD_MUL; mif.u1reg = 32'd3; mif.u2reg = 32'd3;
      end else begin
        mif.req = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mif.req = 1'b0;
    checks++;
    if (mif.rdata !== 32'd14 || cyc != 34) begin
      errors++;
      $display("FAIL req_while_busy: rdata=%h cycle=%0d required %h cycle 34", mif.rdata, cyc, 32'd14);
    end
  endtask

  task automatic test_kill();
    bit saw_done;
    mif.fct3 = MD_DIV; mif.u1reg = 32'd1000; mif.u2reg = 32'd3; mif.req = 1'b1;
    @(posedge clk); #1;
    mif.req = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    mif.kill = 1'b1;
    @(posedge clk); #1;
    mif.kill = 1'b0;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.rdata !== 32'd14) begin
      errors++;
      $display("FAIL kill_run: busy=%b done=%b rdata=%h required 0/0/%h", mif.busy, mif.done, mif.rdata, 32'd14);
    end
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (mif.done || mif.busy) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL kill_no_done: activity after kill=%b required 0", saw_done);
    end
    mif.req = 1'b1; mif.kill = 1'b1; mif.fct3 = MD_MUL;
    @(posedge clk); #1;
    mif.req = 1'b0; mif.kill = 1'b0;
    checks++;
    if (mif.busy !== 1'b0 || mif.rdata !== 32'd14) begin
      errors++;
      $display("FAIL kill_with_req: busy=%b rdata=%h required 0/%h", mif.busy, mif.rdata, 32'd14);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          cyc;
    run_op(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, cyc);
    checks++;
    if (res !== 32'hFFFFFFFE || mif.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: rdata=%h done=%b required %h/1", res, mif.done, 32'hFFFFFFFE);
    end
    mif.fct3 = MD_REMU; mif.u1reg = 32'd100; mif.u2reg = 32'd7; mif.req = 1'b1;
    @(posedge clk); #1;
    mif.req = 1'b0;
    checks++;
    if (mif.busy !== 1'b1 || mif.done !== 1'b0 || mif.rdata !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b rdata=%h required 1/0/%h", mif.busy, mif.done, mif.rdata, 32'hFFFFFFFE);
    end
    cyc = 1;
    while (!mif.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (mif.rdata !== 32'd2 || cyc != 34) begin
      errors++;
      $display("FAIL b2b_second: rdata=%h cycle=%0d required %h cycle 34", mif.rdata, cyc, 32'd2);
    end
  endtask

  task automatic test_reset_mid();
    mif.fct3 = MD_MUL; mif.u1reg = 32'd9; mif.u2reg = 32'd9; mif.req = 1'b1;
    @(posedge clk); #1;
    mif.req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 resn = 1'b0;
    #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b rdata=%h required 0/0/0", mif.busy, mif.done, mif.rdata);
    end
    @(negedge clk); resn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    mif.req = 1'b0; mif.kill = 1'b0; mif.fct3 = 3'd0; mif.u1reg = '0; mif.u2reg = '0;
    test_reset();
    test_directed();
    test_random();
    test_req_ignored();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
